// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer: Moore FSM driving datapath selects and write strobes.
// Latency: 2 to 5 cycles per instruction (illegal op 2, beq/bne/j 3, sw/R/imm 4, lw 5).
// Backpressure: none; the datapath follows the FSM every cycle, one instruction in flight.
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   op, funct, zero    instruction fields from the IR and the ALU zero flag
//   iord .. pcen       datapath mux selects, write strobes and PC write enable
//   instr_done         1-cycle pulse in the last state of each legal instruction
//   illegal            sticky flag for an unsupported op or funct, cleared only by reset
module mc_ctrl_fsm #(
  parameter bit EN_BNE       = 1'b1,
  parameter bit EN_IMM_LOGIC = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       extop,
  output logic [2:0] alucontrol,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BREX    = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  state_t state, state_nxt;
  logic   set_illegal;

  // Opcode decode; optional opcodes vanish when their feature is disabled,
  // so they fall through to the illegal path in DECODE.
  logic is_lw, is_sw, is_r, is_beq, is_bne, is_j;
  logic is_addi, is_andi, is_ori, is_slti, is_imm;
  logic [2:0] imm_alu;
  logic       imm_zext;

  always_comb begin
    is_lw   = (op == OP_LW);
    is_sw   = (op == OP_SW);
    is_r    = (op == OP_R);
    is_beq  = (op == OP_BEQ);
    is_bne  = EN_BNE && (op == OP_BNE);
    is_j    = (op == OP_J);
    is_addi = (op == OP_ADDI);
    is_andi = EN_IMM_LOGIC && (op == OP_ANDI);
    is_ori  = EN_IMM_LOGIC && (op == OP_ORI);
    is_slti = EN_IMM_LOGIC && (op == OP_SLTI);
    is_imm  = is_addi | is_andi | is_ori | is_slti;

    imm_alu  = ALU_ADD;
    imm_zext = 1'b0;
    if (is_andi) begin
      imm_alu  = ALU_AND;
      imm_zext = 1'b1;
    end else if (is_ori) begin
      imm_alu  = ALU_OR;
      imm_zext = 1'b1;
    end else if (is_slti) begin
      imm_alu  = ALU_SLT;
    end
  end

  // R-type funct decode
  logic [2:0] r_alu;
  logic       funct_ok;

  always_comb begin
    r_alu    = ALU_ADD;
    funct_ok = 1'b1;
    case (funct)
      6'b100000: r_alu = ALU_ADD;
      6'b100010: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b101010: r_alu = ALU_SLT;
      default:   funct_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            illegal <= 1'b0;
    else if (set_illegal) illegal <= 1'b1;
  end

  // Outputs follow the state only, except the branch pcen (needs zero) and
  // the ALU codes (need op/funct held in the IR). While reset is high every
  // output stays at its zero default so no strobe leaks out.
  always_comb begin
    state_nxt   = state;
    set_illegal = 1'b0;
    iord        = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    extop       = 1'b0;
    alucontrol  = ALU_AND;
    pcsrc       = 2'b00;
    pcen        = 1'b0;
    instr_done  = 1'b0;

    if (reset) begin
      state_nxt = S_FETCH;
    end else begin
      case (state)
        S_FETCH: begin
          irwrite    = 1'b1;
          alusrcb    = 2'b01;
          alucontrol = ALU_ADD;
          pcen       = 1'b1;
          state_nxt  = S_DECODE;
        end
        S_DECODE: begin
          // branch target computed speculatively into ALUOut
          alusrcb    = 2'b11;
          alucontrol = ALU_ADD;
          if (is_lw || is_sw)         state_nxt = S_MEMADR;
          else if (is_r)              state_nxt = S_RTYPEEX;
          else if (is_beq || is_bne)  state_nxt = S_BREX;
          else if (is_imm)            state_nxt = S_IMMEX;
          else if (is_j)              state_nxt = S_JEX;
          else begin
            set_illegal = 1'b1;
            state_nxt   = S_FETCH;
          end
        end
        S_MEMADR: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          alucontrol = ALU_ADD;
          state_nxt  = is_lw ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          iord      = 1'b1;
          state_nxt = S_MEMWB;
        end
        S_MEMWB: begin
          memtoreg   = 1'b1;
          regwrite   = 1'b1;
          instr_done = 1'b1;
          state_nxt  = S_FETCH;
        end
        S_MEMWR: begin
          iord       = 1'b1;
          memwrite   = 1'b1;
          instr_done = 1'b1;
          state_nxt  = S_FETCH;
        end
        S_RTYPEEX: begin
          alusrca    = 1'b1;
          alucontrol = r_alu;
          if (funct_ok) begin
            state_nxt = S_ALUWB;
          end else begin
            // bad funct: abandon the instruction without writeback
            set_illegal = 1'b1;
            state_nxt   = S_FETCH;
          end
        end
        S_ALUWB: begin
          regdst     = 1'b1;
          regwrite   = 1'b1;
          instr_done = 1'b1;
          state_nxt  = S_FETCH;
        end
        S_BREX: begin
          alusrca    = 1'b1;
          alucontrol = ALU_SUB;
          pcsrc      = 2'b01;
          pcen       = zero ^ is_bne;
          instr_done = 1'b1;
          state_nxt  = S_FETCH;
        end
        S_IMMEX: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          alucontrol = imm_alu;
          extop      = imm_zext;
          state_nxt  = S_IMMWB;
        end
        S_IMMWB: begin
          // extension kept stable so the immediate path does not glitch
          extop      = imm_zext;
          alucontrol = imm_alu;
          regwrite   = 1'b1;
          instr_done = 1'b1;
          state_nxt  = S_FETCH;
        end
        S_JEX: begin
          pcsrc      = 2'b10;
          pcen       = 1'b1;
          instr_done = 1'b1;
          state_nxt  = S_FETCH;
        end
        default: state_nxt = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed scenarios plus random instruction streams.
// Latency: each instruction is walked cycle by cycle against an expected step list.
// Backpressure: not applicable; stimulus is driven every cycle.
module tb_mc_ctrl_fsm;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       extop;
        logic [2:0] alucontrol;
        logic [1:0] pcsrc;
        logic       pcen;
        logic       instr_done;
    } ctl_t;

    // memwrite, irwrite, regwrite, pcen, instr_done
    localparam ctl_t STROBES = ctl_t'(17'h0C803);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam int C_ILL = 0, C_LW = 1, C_SW = 2, C_R = 3, C_BR = 4, C_IMM = 5, C_J = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;

    logic iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, extop, pcen, instr_done, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic iord_m, memwrite_m, irwrite_m, regdst_m, memtoreg_m, regwrite_m, alusrca_m, extop_m, pcen_m;
    logic instr_done_m, illegal_m;
    logic [1:0] alusrcb_m, pcsrc_m;
    logic [2:0] alucontrol_m;

    ctl_t obs, obs_m;
    assign obs   = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb,
                    extop, alucontrol, pcsrc, pcen, instr_done};
    assign obs_m = {iord_m, memwrite_m, irwrite_m, regdst_m, memtoreg_m, regwrite_m, alusrca_m,
                    alusrcb_m, extop_m, alucontrol_m, pcsrc_m, pcen_m, instr_done_m};

    mc_ctrl_fsm u_dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .extop(extop), .alucontrol(alucontrol), .pcsrc(pcsrc), .pcen(pcen),
        .instr_done(instr_done), .illegal(illegal)
    );

    mc_ctrl_fsm #(.EN_BNE(1'b0), .EN_IMM_LOGIC(1'b0)) u_dut_min (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .iord(iord_m), .memwrite(memwrite_m), .irwrite(irwrite_m), .regdst(regdst_m),
        .memtoreg(memtoreg_m), .regwrite(regwrite_m), .alusrca(alusrca_m), .alusrcb(alusrcb_m),
        .extop(extop_m), .alucontrol(alucontrol_m), .pcsrc(pcsrc_m), .pcen(pcen_m),
        .instr_done(instr_done_m), .illegal(illegal_m)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Expected per-cycle outputs of one instruction, with a care mask.
    ctl_t ev [8];
    ctl_t em [8];
    int   n_cyc;
    bit   m_ill;
    bit   sticky;

    logic [5:0] legal_ops [10] = '{OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW, OP_SW};
    logic [5:0] legal_fn  [5]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    function automatic int op_class(input logic [5:0] o);
        case (o)
            OP_LW:                             return C_LW;
            OP_SW:                             return C_SW;
            OP_R:                              return C_R;
            OP_BEQ, OP_BNE:                    return C_BR;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: return C_IMM;
            OP_J:                              return C_J;
            default:                           return C_ILL;
        endcase
    endfunction

    // {legal, alu code}
    function automatic logic [3:0] r_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 4'b1_010;
            6'b100010: return 4'b1_110;
            6'b100100: return 4'b1_000;
            6'b100101: return 4'b1_001;
            6'b101010: return 4'b1_111;
            default:   return 4'b0_000;
        endcase
    endfunction

    // {zero-extend, alu code}
    function automatic logic [3:0] imm_alu(input logic [5:0] o);
        case (o)
            OP_ANDI: return 4'b1_000;
            OP_ORI:  return 4'b1_001;
            OP_SLTI: return 4'b0_111;
            default: return 4'b0_010;
        endcase
    endfunction

    task automatic push(input ctl_t v, input ctl_t m);
        ev[n_cyc] = v;
        em[n_cyc] = m;
        n_cyc++;
    endtask

    // Step list of one instruction, straight from the instruction-class rules.
    task automatic build_model(input logic [5:0] o, input logic [5:0] f, input logic z);
        ctl_t v, m;
        int c;
        logic [3:0] ra, ia;
        n_cyc = 0;
        m_ill = 1'b0;
        c  = op_class(o);
        ra = r_alu(f);
        ia = imm_alu(o);
        v = '0; m = STROBES;
        v.irwrite = 1; v.alusrcb = 2'b01; v.alucontrol = 3'b010; v.pcen = 1;
        m.iord = 1; m.alusrca = 1; m.alusrcb = '1; m.alucontrol = '1; m.pcsrc = '1;
        push(v, m);
        v = '0; m = STROBES;
        v.alusrcb = 2'b11; v.alucontrol = 3'b010;
        m.alusrca = 1; m.alusrcb = '1; m.alucontrol = '1;
        push(v, m);
        case (c)
            C_LW, C_SW: begin
                v = '0; m = STROBES;
                v.alusrca = 1; v.alusrcb = 2'b10; v.alucontrol = 3'b010;
                m.alusrca = 1; m.alusrcb = '1; m.extop = 1; m.alucontrol = '1;
                push(v, m);
                if (c == C_LW) begin
                    v = '0; m = STROBES; v.iord = 1; m.iord = 1;
                    push(v, m);
                    v = '0; m = STROBES; v.memtoreg = 1; v.regwrite = 1; v.instr_done = 1;
                    m.regdst = 1; m.memtoreg = 1;
                    push(v, m);
                end else begin
                    v = '0; m = STROBES; v.iord = 1; v.memwrite = 1; v.instr_done = 1; m.iord = 1;
                    push(v, m);
                end
            end
            C_R: begin
                v = '0; m = STROBES; v.alusrca = 1; m.alusrca = 1; m.alusrcb = '1;
                if (ra[3]) begin v.alucontrol = ra[2:0]; m.alucontrol = '1; end
                push(v, m);
                if (ra[3]) begin
                    v = '0; m = STROBES; v.regdst = 1; v.regwrite = 1; v.instr_done = 1;
                    m.regdst = 1; m.memtoreg = 1;
                    push(v, m);
                end else begin
                    m_ill = 1'b1;
                end
            end
            C_BR: begin
                v = '0; m = STROBES;
                v.alusrca = 1; v.alucontrol = 3'b110; v.pcsrc = 2'b01;
                v.pcen = z ^ (o == OP_BNE); v.instr_done = 1;
                m.alusrca = 1; m.alusrcb = '1; m.alucontrol = '1; m.pcsrc = '1;
                push(v, m);
            end
            C_IMM: begin
                v = '0; m = STROBES;
                v.alusrca = 1; v.alusrcb = 2'b10; v.alucontrol = ia[2:0]; v.extop = ia[3];
                m.alusrca = 1; m.alusrcb = '1; m.alucontrol = '1; m.extop = 1;
                push(v, m);
                v = '0; m = STROBES; v.regwrite = 1; v.instr_done = 1; v.extop = ia[3];
                m.regdst = 1; m.memtoreg = 1; m.extop = 1;
                push(v, m);
            end
            C_J: begin
                v = '0; m = STROBES; v.pcsrc = 2'b10; v.pcen = 1; v.instr_done = 1; m.pcsrc = '1;
                push(v, m);
            end
            default: m_ill = 1'b1;
        endcase
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if ((obs & STROBES) !== '0 || illegal !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_strobes cyc %0d: got %h ill=%b, want 0000 ill=0", i, obs & STROBES, illegal);
            end
            tests_run++;
            if ((obs_m & STROBES) !== '0 || illegal_m !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_strobes_min cyc %0d: got %h ill=%b, want 0 ill=0", i, obs_m & STROBES, illegal_m);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        tests_run++;
        if ({irwrite, pcen, alusrcb, memwrite, regwrite} !== 6'b11_01_00) begin
            tests_failed++;
            $display("FAIL reset_first_fetch: got %b want 110100", {irwrite, pcen, alusrcb, memwrite, regwrite});
        end
    endtask

    task automatic test_lw();
        int dn = 0;
        op = OP_LW; funct = 6'($urandom); zero = 1'($urandom);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            tests_run++;
            if ({regwrite, memtoreg} !== ((c == 5) ? 2'b11 : 2'b00)) begin
                tests_failed++;
                $display("FAIL lw_wb cyc %0d: got %b want %b", c, {regwrite, memtoreg}, (c == 5) ? 2'b11 : 2'b00);
            end
            if (instr_done) dn++;
            if (c == 4) begin
                tests_run++;
                if (iord !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL lw_iord: got %b want 1", iord);
                end
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if (dn != 1) begin
            tests_failed++;
            $display("FAIL lw_done_count: got %0d want 1", dn);
        end
    endtask

    task automatic test_sw();
        op = OP_SW; funct = 6'($urandom); zero = 1'($urandom);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            tests_run++;
            if ({memwrite, regwrite, instr_done} !== ((c == 4) ? 3'b101 : 3'b000)) begin
                tests_failed++;
                $display("FAIL sw_strobes cyc %0d: got %b want %b", c, {memwrite, regwrite, instr_done},
                         (c == 4) ? 3'b101 : 3'b000);
            end
            if (c == 4) begin
                tests_run++;
                if (iord !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL sw_iord: got %b want 1", iord);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        for (int t = 0; t < 4; t++) begin
            logic isb, z;
            isb = t[1]; z = t[0];
            op = isb ? OP_BNE : OP_BEQ; zero = z; funct = 6'($urandom);
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                if (c == 2) begin
                    tests_run++;
                    if (pcen !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL br_decode_pcen bne=%b: got %b want 0", isb, pcen);
                    end
                end
                if (c == 3) begin
                    tests_run++;
                    if ({pcen, pcsrc, alucontrol, instr_done} !== {z ^ isb, 2'b01, 3'b110, 1'b1}) begin
                        tests_failed++;
                        $display("FAIL br_ex bne=%b zero=%b: got %b want %b", isb, z,
                                 {pcen, pcsrc, alucontrol, instr_done}, {z ^ isb, 2'b01, 3'b110, 1'b1});
                    end
                end
                @(posedge clk); #1;
            end
            tests_run++;
            if (irwrite !== 1'b1) begin
                tests_failed++;
                $display("FAIL br_back_to_fetch: got %b want 1", irwrite);
            end
        end
    endtask

    task automatic test_rtype();
        op = OP_R; funct = 6'b100010;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 3) begin
                tests_run++;
                if ({alucontrol, alusrca, alusrcb} !== 6'b110_1_00) begin
                    tests_failed++;
                    $display("FAIL r_sub_ex: got %b want 110100", {alucontrol, alusrca, alusrcb});
                end
            end
            if (c == 4) begin
                tests_run++;
                if ({regdst, regwrite, memtoreg, instr_done} !== 4'b1101) begin
                    tests_failed++;
                    $display("FAIL r_sub_wb: got %b want 1101", {regdst, regwrite, memtoreg, instr_done});
                end
            end
            @(posedge clk); #1;
        end
        funct = 6'b000111;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            tests_run++;
            if ({regwrite, instr_done, illegal} !== 3'b000) begin
                tests_failed++;
                $display("FAIL r_bad_nowb cyc %0d: got %b want 000", c, {regwrite, instr_done, illegal});
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if ({irwrite, illegal} !== 2'b11) begin
            tests_failed++;
            $display("FAIL r_bad_illegal: got %b want 11", {irwrite, illegal});
        end
    endtask

    task automatic test_illegal_sticky();
        logic [5:0] ops [3];
        ops = '{6'b111111, 6'b010000, OP_J};
        do_reset();
        tests_run++;
        if (illegal !== 1'b0) begin
            tests_failed++;
            $display("FAIL ill_cleared: got %b want 0", illegal);
        end
        for (int i = 0; i < 3; i++) begin
            op = ops[i];
            for (int c = 1; c <= ((i == 2) ? 3 : 2); c++) begin
                @(negedge clk);
                tests_run++;
                if (instr_done !== (i == 2 && c == 3)) begin
                    tests_failed++;
                    $display("FAIL ill_done op=%b cyc %0d: got %b want %b", op, c, instr_done, (i == 2 && c == 3));
                end
                @(posedge clk); #1;
            end
            tests_run++;
            if ({irwrite, illegal} !== 2'b11) begin
                tests_failed++;
                $display("FAIL ill_sticky op=%b: got %b want 11", op, {irwrite, illegal});
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        op = OP_SW;
        for (int c = 1; c <= 3; c++) begin @(posedge clk); #1; end
        @(negedge clk);
        tests_run++;
        if (memwrite !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_memwr: got %b want 1", memwrite);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if ((obs & STROBES) !== '0) begin
            tests_failed++;
            $display("FAIL mid_drop: got %h want 0", obs & STROBES);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        tests_run++;
        if ({irwrite, pcen, memwrite, illegal} !== 4'b1100) begin
            tests_failed++;
            $display("FAIL mid_refetch: got %b want 1100", {irwrite, pcen, memwrite, illegal});
        end
    endtask

    task automatic test_params();
        logic [5:0] ops [5];
        logic       exp_ill [5];
        ops     = '{OP_BNE, OP_ANDI, OP_ORI, OP_SLTI, OP_ADDI};
        exp_ill = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            do_reset();
            op = ops[i]; zero = 1'($urandom);
            @(posedge clk); #1;
            @(posedge clk); #1;
            tests_run++;
            if ({illegal_m, irwrite_m} !== {exp_ill[i], exp_ill[i]}) begin
                tests_failed++;
                $display("FAIL param_min op=%b: got %b want %b", ops[i], {illegal_m, irwrite_m},
                         {exp_ill[i], exp_ill[i]});
            end
            tests_run++;
            if ({illegal, irwrite} !== 2'b00) begin
                tests_failed++;
                $display("FAIL param_full op=%b: got %b want 00", ops[i], {illegal, irwrite});
            end
        end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        sticky = 1'b0;
        for (int i = 0; i < 300; i++) begin
            logic [5:0] o, f;
            logic z;
            o = ($urandom_range(0, 9) < 8) ? legal_ops[$urandom_range(0, 9)] : 6'($urandom);
            f = ($urandom_range(0, 9) < 7) ? legal_fn[$urandom_range(0, 4)] : 6'($urandom);
            z = 1'($urandom);
            op = o; funct = f; zero = z;
            build_model(o, f, z);
            for (int k = 0; k < n_cyc; k++) begin
                @(negedge clk);
                tests_run++;
                if (((obs ^ ev[k]) & em[k]) !== '0) begin
                    tests_failed++;
                    $display("FAIL rand_ctl #%0d op=%b funct=%b zero=%b cyc %0d: got %h want %h mask %h",
                             i, o, f, z, k + 1, obs & em[k], ev[k] & em[k], em[k]);
                end
                tests_run++;
                if (illegal !== sticky) begin
                    tests_failed++;
                    $display("FAIL rand_illegal #%0d cyc %0d: got %b want %b", i, k + 1, illegal, sticky);
                end
                @(posedge clk); #1;
            end
            sticky = sticky | m_ill;
        end
        tests_run++;
        if (illegal !== sticky) begin
            tests_failed++;
            $display("FAIL rand_illegal_final: got %b want %b", illegal, sticky);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_branch();
        test_rtype();
        test_illegal_sticky();
        test_reset_mid();
        test_params();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
